// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way write-back cache: FSM states, width math and
// address field extraction.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StRefill,
    StRespond
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Extract a width-bit field starting at bit lsb; callers cast to the field width.
  function automatic logic [63:0] adr_field(input logic [63:0] adr, input int unsigned lsb,
                                            input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (adr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Per-set true-LRU age tracking: ages form a permutation of 0..WAYS-1 per set, with 0 the
// most recently used way. Also picks the replacement victim.
module cache_lru_ages
  import cache_pkg::*;
#(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 128,
  localparam int unsigned AGE_W = clog2(WAYS),
  localparam int unsigned IDX_W = clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAYS-1:0]  i_valid,
  input  logic             i_upd,
  input  logic [AGE_W-1:0] i_way,
  output logic [AGE_W-1:0] o_victim
);

  logic [AGE_W-1:0] r_age [SETS][WAYS];
  logic [AGE_W-1:0] w_age_sel;
  logic             w_found;

  assign w_age_sel = r_age[i_idx][i_way];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= AGE_W'(w);
        end
      end
    end else if (i_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == i_way) begin
          r_age[i_idx][w] <= '0;
        end else if (r_age[i_idx][w] < w_age_sel) begin
          r_age[i_idx][w] <= r_age[i_idx][w] + 1'b1;
        end
      end
    end
  end

  // Invalid ways are always the oldest, so filling them first keeps ages in recency order.
  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !i_valid[w]) begin
        o_victim = AGE_W'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[i_idx][w] == AGE_W'(WAYS - 1)) o_victim = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with dirty-victim writeback and
// critical-word-first wrapping refill over a word-serial memory handshake.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADR_WIDTH  = 32,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 128,
  parameter int unsigned WORDS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADR_WIDTH-1:0]  cpu_adr_i,
  input  logic [WORD_WIDTH-1:0] cpu_dat_i,
  output logic                  cpu_ack_o,
  output logic [WORD_WIDTH-1:0] cpu_dat_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADR_WIDTH-1:0]  mem_adr_o,
  output logic [WORD_WIDTH-1:0] mem_dat_o,
  input  logic                  mem_ack_i,
  input  logic [WORD_WIDTH-1:0] mem_dat_i
);

  localparam int unsigned OFF_W = clog2(WORDS);
  localparam int unsigned IDX_W = clog2(SETS);
  localparam int unsigned AGE_W = clog2(WAYS);
  localparam int unsigned TAG_W = ADR_WIDTH - IDX_W - OFF_W - 2;
  localparam int unsigned LIN_W = IDX_W + AGE_W + OFF_W;

  state_e r_state, w_state_d;

  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic [OFF_W-1:0]      r_off;
  logic                  r_we;
  logic [WORD_WIDTH-1:0] r_wdat;

  logic [TAG_W-1:0]      r_tag_arr [SETS][WAYS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];
  logic [WORD_WIDTH-1:0] r_data [SETS*WAYS*WORDS];
  logic [TAG_W-1:0]      r_rd_tag [WAYS];
  logic [WORD_WIDTH-1:0] r_rd_word [WAYS];

  logic [AGE_W-1:0]      r_victim;
  logic [TAG_W-1:0]      r_vtag;
  logic [OFF_W-1:0]      r_beat;

  logic                  w_accept;
  logic [TAG_W-1:0]      w_in_tag;
  logic [IDX_W-1:0]      w_in_idx;
  logic [OFF_W-1:0]      w_in_off;
  logic                  w_hit;
  logic [AGE_W-1:0]      w_hit_way;
  logic [AGE_W-1:0]      w_lru_victim;
  logic                  w_lru_upd;
  logic [AGE_W-1:0]      w_lru_way;
  logic                  w_victim_dirty;
  logic [OFF_W-1:0]      w_word;
  logic                  w_last_beat;
  logic                  w_dwe;
  logic [LIN_W-1:0]      w_daddr;
  logic [WORD_WIDTH-1:0] w_ddat;

  assign w_in_off = OFF_W'(adr_field(64'(cpu_adr_i), 2, OFF_W));
  assign w_in_idx = IDX_W'(adr_field(64'(cpu_adr_i), 2 + OFF_W, IDX_W));
  assign w_in_tag = TAG_W'(adr_field(64'(cpu_adr_i), 2 + OFF_W + IDX_W, TAG_W));
  assign w_accept = (r_state == StIdle) && cpu_req_i;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[r_idx][w] && (r_rd_tag[w] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
    end
  end

  assign w_victim_dirty = r_valid[r_idx][w_lru_victim] && r_dirty[r_idx][w_lru_victim];
  // Writeback walks the line from word 0; refill starts at the requested word and wraps.
  assign w_word         = (r_state == StWriteback) ? r_beat : r_off + r_beat;
  assign w_last_beat    = mem_ack_i && (r_beat == OFF_W'(WORDS - 1));
  assign w_lru_upd      = ((r_state == StLookup) && w_hit) || (r_state == StRespond);
  assign w_lru_way      = (r_state == StRespond) ? r_victim : w_hit_way;

  cache_lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk      (clk),
    .rst      (rst),
    .i_idx    (r_idx),
    .i_valid  (r_valid[r_idx]),
    .i_upd    (w_lru_upd),
    .i_way    (w_lru_way),
    .o_victim (w_lru_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:      if (cpu_req_i) w_state_d = StLookup;
      StLookup: begin
        if (w_hit)               w_state_d = StIdle;
        else if (w_victim_dirty) w_state_d = StWriteback;
        else                     w_state_d = StRefill;
      end
      StWriteback: if (w_last_beat) w_state_d = StRefill;
      StRefill:    if (w_last_beat) w_state_d = StRespond;
      StRespond:   w_state_d = StIdle;
      default:     w_state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_ack_o = 1'b0;
    cpu_dat_o = '0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    unique case (r_state)
      StLookup: begin
        if (w_hit) begin
          cpu_ack_o = 1'b1;
          cpu_dat_o = r_rd_word[w_hit_way];
        end
      end
      StWriteback: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_adr_o = {r_vtag, r_idx, w_word, 2'b00};
        mem_dat_o = r_data[{r_idx, r_victim, w_word}];
      end
      StRefill: begin
        mem_req_o = 1'b1;
        mem_adr_o = {r_tag, r_idx, w_word, 2'b00};
      end
      StRespond: begin
        cpu_ack_o = 1'b1;
        cpu_dat_o = r_data[{r_idx, r_victim, r_off}];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag  <= w_in_tag;
      r_idx  <= w_in_idx;
      r_off  <= w_in_off;
      r_we   <= cpu_we_i;
      r_wdat <= cpu_dat_i;
      for (int w = 0; w < WAYS; w++) begin
        r_rd_tag[w]  <= r_tag_arr[w_in_idx][w];
        r_rd_word[w] <= r_data[{w_in_idx, AGE_W'(w), w_in_off}];
      end
    end
    if (r_state == StLookup) begin
      r_victim <= w_lru_victim;
      r_vtag   <= r_rd_tag[w_lru_victim];
      r_beat   <= '0;
    end else if (((r_state == StWriteback) || (r_state == StRefill)) && mem_ack_i) begin
      r_beat <= r_beat + 1'b1;
    end
    if (r_state == StRespond) r_tag_arr[r_idx][r_victim] <= r_tag;
  end

  // The victim is invalidated on a miss so an aborted refill never leaves a live line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else if (r_state == StLookup) begin
      if (w_hit) begin
        if (r_we) r_dirty[r_idx][w_hit_way] <= 1'b1;
      end else begin
        r_valid[r_idx][w_lru_victim] <= 1'b0;
        r_dirty[r_idx][w_lru_victim] <= 1'b0;
      end
    end else if (r_state == StRespond) begin
      r_valid[r_idx][r_victim] <= 1'b1;
      r_dirty[r_idx][r_victim] <= r_we;
    end
  end

  always_comb begin
    w_dwe   = 1'b0;
    w_daddr = {r_idx, r_victim, r_off};
    w_ddat  = r_wdat;
    unique case (r_state)
      StLookup: begin
        w_dwe   = w_hit && r_we;
        w_daddr = {r_idx, w_hit_way, r_off};
      end
      StRefill: begin
        w_dwe   = mem_ack_i;
        w_daddr = {r_idx, r_victim, w_word};
        w_ddat  = mem_dat_i;
      end
      StRespond: w_dwe = r_we;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_dwe) r_data[w_daddr] <= w_ddat;
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Randomised scoreboard bench for cache_nway_wb against a recency-list cache model and a
// backing memory with variable beat latency.
module tb_cache_nway_wb;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_adr_i = '0;
  logic [31:0] cpu_dat_i = '0;
  logic        cpu_ack_o;
  logic [31:0] cpu_dat_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_dat_i = '0;

  always #5 clk = ~clk;

  cache_nway_wb dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req_i (cpu_req_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_adr_i (cpu_adr_i),
    .cpu_dat_i (cpu_dat_i),
    .cpu_ack_o (cpu_ack_o),
    .cpu_dat_o (cpu_dat_o),
    .mem_req_o (mem_req_o),
    .mem_we_o  (mem_we_o),
    .mem_adr_o (mem_adr_o),
    .mem_dat_o (mem_dat_o),
    .mem_ack_i (mem_ack_i),
    .mem_dat_i (mem_dat_i)
  );

  typedef struct packed {
    logic [31:0]  base;
    logic         dirty;
    logic [127:0] data;
    logic [31:0]  stamp;
  } line_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  typedef struct packed {
    logic        rd;
    logic [31:0] dat;
  } resp_t;

  line_t       model_q[$];
  beat_t       exp_mem[$];
  resp_t       exp_cpu[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];
  int unsigned stamp = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          delay_mode = -1;
  int          ref_acks = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // LRU cache model: flat list of lines, recency by stamp, evict oldest once a set is full.
  task automatic predict(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         output logic hit, output logic [31:0] rdata);
    logic [31:0] base;
    int          off;
    int          idx;
    int          cnt;
    int          oldest;
    line_t       e;
    beat_t       b;
    base   = {adr[31:4], 4'h0};
    off    = int'(adr[3:2]);
    idx    = -1;
    cnt    = 0;
    oldest = -1;
    stamp++;
    foreach (model_q[i]) if (model_q[i].base == base) idx = i;
    if (idx >= 0) begin
      hit   = 1'b1;
      e     = model_q[idx];
      rdata = e.data[off*32 +: 32];
      if (we) begin
        e.data[off*32 +: 32] = dat;
        e.dirty = 1'b1;
      end
      e.stamp = stamp;
      model_q[idx] = e;
      return;
    end
    hit = 1'b0;
    foreach (model_q[i]) begin
      if (model_q[i].base[10:4] == base[10:4]) begin
        cnt++;
        if (oldest < 0 || model_q[i].stamp < model_q[oldest].stamp) oldest = i;
      end
    end
    if (cnt == WAYS) begin
      e = model_q[oldest];
      if (e.dirty) begin
        for (int k = 0; k < WORDS; k++) begin
          b.we  = 1'b1;
          b.adr = e.base + 32'(4 * k);
          b.dat = e.data[k*32 +: 32];
          exp_mem.push_back(b);
          ref_mem[b.adr] = b.dat;
        end
      end
      model_q.delete(oldest);
    end
    for (int k = 0; k < WORDS; k++) begin
      b.we  = 1'b0;
      b.adr = base + 32'(4 * ((off + k) % WORDS));
      b.dat = '0;
      exp_mem.push_back(b);
    end
    e.base  = base;
    e.stamp = stamp;
    e.dirty = we;
    for (int k = 0; k < WORDS; k++) e.data[k*32 +: 32] = ref_rd(base + 32'(4 * k));
    rdata = e.data[off*32 +: 32];
    if (we) e.data[off*32 +: 32] = dat;
    model_q.push_back(e);
  endtask

  task automatic cpu_op(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    logic        hit;
    logic [31:0] rd;
    resp_t       r;
    int          n;
    @(negedge clk);
    predict(adr, we, dat, hit, rd);
    r.rd  = !we;
    r.dat = rd;
    exp_cpu.push_back(r);
    cpu_req_i = 1'b1;
    cpu_we_i  = we;
    cpu_adr_i = adr;
    cpu_dat_i = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack_o && n < 400);
    cpu_req_i = 1'b0;
    if (!cpu_ack_o) begin
      n_fail++;
      $display("FAIL ack_timeout adr %h: no cpu_ack_o within %0d cycles", adr, n);
      report();
    end
    if (hit) chk("hit_latency", 32'(n), 32'd1);
  endtask

  // CPU-side monitor.
  initial begin
    resp_t c;
    forever begin
      @(negedge clk);
      if (!rst && cpu_ack_o) begin
        n_cmp++;
        if (exp_cpu.size() == 0) begin
          n_fail++;
          $display("FAIL cpu_ack spurious ack, data %h, required no ack", cpu_dat_o);
        end else begin
          c = exp_cpu.pop_front();
          if (c.rd && cpu_dat_o !== c.dat) begin
            n_fail++;
            $display("FAIL cpu_rdata got %h required %h", cpu_dat_o, c.dat);
          end
        end
      end
    end
  end

  // Memory responder and memory-side monitor.
  initial begin
    logic        waiting;
    int          wait_left;
    logic [64:0] prev;
    beat_t       b;
    waiting   = 1'b0;
    wait_left = 0;
    prev      = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (rst) begin
        waiting = 1'b0;
      end else if (mem_req_o) begin
        if (waiting) begin
          n_cmp++;
          if ({mem_we_o, mem_adr_o, mem_dat_o} !== prev) begin
            n_fail++;
            $display("FAIL beat_stable got %h required %h", {mem_we_o, mem_adr_o, mem_dat_o},
                     prev);
          end
        end else begin
          wait_left = (delay_mode < 0) ? int'($urandom_range(2, 0)) : delay_mode;
        end
        if (wait_left == 0) begin
          mem_ack_i = 1'b1;
          waiting   = 1'b0;
          n_cmp++;
          if (exp_mem.size() == 0) begin
            n_fail++;
            $display("FAIL mem_beat unexpected we=%0b adr=%h, required none", mem_we_o,
                     mem_adr_o);
          end else begin
            b = exp_mem.pop_front();
            if (mem_we_o !== b.we || mem_adr_o !== b.adr || (b.we && mem_dat_o !== b.dat)) begin
              n_fail++;
              $display("FAIL mem_beat got we=%0b adr=%h dat=%h required we=%0b adr=%h dat=%h",
                       mem_we_o, mem_adr_o, mem_dat_o, b.we, b.adr, b.dat);
            end
          end
          if (mem_we_o) begin
            mem_arr[mem_adr_o] = mem_dat_o;
          end else begin
            mem_dat_i = mem_rd(mem_adr_o);
            ref_acks++;
          end
        end else begin
          wait_left--;
          waiting = 1'b1;
          prev    = {mem_we_o, mem_adr_o, mem_dat_o};
        end
      end else begin
        waiting = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hit;
    logic [31:0] rd;
    int          n;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
    chk("rst_cpu_dat", cpu_dat_o, 32'd0);
    chk("rst_mem_req_idle", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_adr", mem_adr_o, 32'd0);
    chk("rst_mem_dat", mem_dat_o, 32'd0);

    cpu_op(32'h10, 1'b0, '0);
    cpu_op(32'h10, 1'b0, '0);
    cpu_op(32'h2C, 1'b0, '0);
    cpu_op(32'h14, 1'b1, 32'hDEAD_BEEF);
    cpu_op(32'h810, 1'b0, '0);
    cpu_op(32'h1010, 1'b0, '0);
    cpu_op(32'h1810, 1'b0, '0);
    cpu_op(32'h2010, 1'b0, '0);
    cpu_op(32'h14, 1'b0, '0);

    delay_mode = 3;
    cpu_op(32'h2814, 1'b1, 32'h1234_5678);
    cpu_op(32'h3018, 1'b0, '0);
    cpu_op(32'h3818, 1'b0, '0);
    delay_mode = -1;

    // Reset while the third refill beat is outstanding.
    @(negedge clk);
    predict(32'h7F0, 1'b0, '0, hit, rd);
    ref_acks  = 0;
    cpu_req_i = 1'b1;
    cpu_we_i  = 1'b0;
    cpu_adr_i = 32'h7F0;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (ref_acks < 2 && n < 200);
    chk("rst_test_reach_beat2", 32'(ref_acks), 32'd2);
    rst       = 1'b1;
    cpu_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_cpu_ack", 32'(cpu_ack_o), 32'd0);
    rst = 1'b0;
    model_q.delete();
    exp_mem.delete();
    cpu_op(32'h7F0, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      cpu_op({18'h0, 3'($urandom_range(5, 0)), 5'h0, 2'($urandom), 2'($urandom), 2'b00},
             1'($urandom), $urandom);
    end

    repeat (5) @(negedge clk);
    chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    report();
  end

endmodule
